exe_stage_fwd: RTL and testbench

Parametrised execute stage. It sits between the decode/register-read stage and the memory stage and adds full operand forwarding from MEM and WB. It adds a freeze input, so a downstream stall holds the EX/MEM pipeline register. It adds an iterative multi-cycle unsigned multiplier that writes HI/LO and stalls decode while it runs.

---
 rtl/exe_stage_fwd.sv | 194 +++++++++++++++++++
 tb/tb_exe_stage_fwd.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_fwd.sv
// Execute stage with MEM/WB operand forwarding, a freezable EX/MEM register
// and an iterative shift-add unsigned multiplier writing HI/LO.
module exe_stage_fwd #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int SW = 5
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          id_valid,
  input  logic [3:0]    id_op,
  input  logic [DW-1:0] id_opa,
  input  logic [DW-1:0] id_opb,
  input  logic [RW-1:0] id_rsa,
  input  logic [RW-1:0] id_rsb,
  input  logic [DW-1:0] id_imm,
  input  logic          id_use_imm,
  input  logic [SW-1:0] id_shamt,
  input  logic [RW-1:0] id_wreg,
  input  logic          id_wb,
  input  logic          id_memrd,
  input  logic          id_memwr,
  input  logic          mem_wb,
  input  logic          wb_wb,
  input  logic [RW-1:0] mem_wreg,
  input  logic [RW-1:0] wb_wreg,
  input  logic [DW-1:0] mem_data,
  input  logic [DW-1:0] wb_data,
  input  logic          freeze,
  output logic          exe_busy,
  output logic          ex_valid,
  output logic          ex_wb,
  output logic          ex_memrd,
  output logic          ex_memwr,
  output logic [DW-1:0] ex_result,
  output logic [DW-1:0] ex_storedata,
  output logic [RW-1:0] ex_wreg,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  localparam int CW = $clog2(DW + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_MULT = 4'd9;
  localparam logic [3:0] OP_MFHI = 4'd10;
  localparam logic [3:0] OP_MFLO = 4'd11;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t state_q, state_d;

  logic          [DW-1:0]   fwd_a, fwd_b, op_b;
  logic signed   [DW-1:0]   op_a_s, op_b_s;
  logic                     shamt_big;
  logic          [DW-1:0]   alu_res;
  logic                     accept, mul_start, last_step, mul_finish;

  logic          [DW-1:0]   mcand_p0;
  logic          [2*DW-1:0] acc_p0;
  logic          [CW-1:0]   cnt_p0;
  logic          [RW-1:0]   mul_wreg_p0;
  logic          [DW:0]     step_sum;
  logic          [2*DW-1:0] acc_step;
  logic          [DW-1:0]   fin_lo;

  // Forwarding: MEM is younger than WB so it wins; r0 is hardwired zero.
  always_comb begin
    fwd_a = id_opa;
    if (id_rsa != '0 && mem_wb && mem_wreg == id_rsa)
      fwd_a = mem_data;
    else if (id_rsa != '0 && wb_wb && wb_wreg == id_rsa)
      fwd_a = wb_data;

    fwd_b = id_opb;
    if (id_rsb != '0 && mem_wb && mem_wreg == id_rsb)
      fwd_b = mem_data;
    else if (id_rsb != '0 && wb_wb && wb_wreg == id_rsb)
      fwd_b = wb_data;
  end

  assign op_b      = id_use_imm ? id_imm : fwd_b;
  assign op_a_s    = fwd_a;
  assign op_b_s    = op_b;
  assign shamt_big = (32'(id_shamt) >= 32'(DW));

  always_comb begin
    alu_res = '0;
    case (id_op)
      OP_ADD:  alu_res = fwd_a + op_b;
      OP_SUB:  alu_res = fwd_a - op_b;
      OP_AND:  alu_res = fwd_a & op_b;
      OP_OR:   alu_res = fwd_a | op_b;
      OP_XOR:  alu_res = fwd_a ^ op_b;
      OP_SLT:  alu_res = {{(DW-1){1'b0}}, (op_a_s < op_b_s)};
      OP_SLL:  alu_res = shamt_big ? '0 : (op_b << id_shamt);
      OP_SRL:  alu_res = shamt_big ? '0 : (op_b >> id_shamt);
      OP_SRA:  alu_res = shamt_big ? {DW{op_b[DW-1]}} : DW'(op_b_s >>> id_shamt);
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  assign exe_busy   = (state_q != IDLE);
  assign accept     = id_valid && !freeze && !exe_busy;
  assign mul_start  = accept && (id_op == OP_MULT);
  assign last_step  = (state_q == MUL) && (cnt_p0 == CW'(1));
  assign mul_finish = !freeze && (last_step || state_q == DONE);

  // One shift-add step: add multiplicand into the upper half, shift right.
  assign step_sum = {1'b0, acc_p0[2*DW-1:DW]} + {1'b0, (acc_p0[0] ? mcand_p0 : '0)};
  assign acc_step = {step_sum, acc_p0[DW-1:1]};
  assign fin_lo   = last_step ? acc_step[DW-1:0] : lo;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (mul_start) state_d = MUL;
      MUL:  if (last_step) state_d = freeze ? DONE : IDLE;
      DONE: if (!freeze) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Multiplier stage p0: operand latch, iteration, HI/LO writeback.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_p0 <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (mul_start) begin
      mcand_p0    <= fwd_a;
      acc_p0      <= {{DW{1'b0}}, fwd_b};
      cnt_p0      <= CW'(DW);
      mul_wreg_p0 <= id_wreg;
    end else if (state_q == MUL) begin
      acc_p0 <= acc_step;
      cnt_p0 <= cnt_p0 - CW'(1);
      if (last_step) {hi, lo} <= acc_step;
    end
  end

  // EX/MEM register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ex_valid     <= 1'b0;
      ex_wb        <= 1'b0;
      ex_memrd     <= 1'b0;
      ex_memwr     <= 1'b0;
      ex_result    <= '0;
      ex_storedata <= '0;
      ex_wreg      <= '0;
    end else if (!freeze) begin
      if (mul_finish) begin
        ex_valid     <= 1'b1;
        ex_wb        <= 1'b0;
        ex_memrd     <= 1'b0;
        ex_memwr     <= 1'b0;
        ex_result    <= fin_lo;
        ex_storedata <= '0;
        ex_wreg      <= mul_wreg_p0;
      end else if (accept && id_op != OP_MULT) begin
        ex_valid     <= 1'b1;
        ex_wb        <= id_wb;
        ex_memrd     <= id_memrd;
        ex_memwr     <= id_memwr;
        ex_result    <= alu_res;
        ex_storedata <= fwd_b;
        ex_wreg      <= id_wreg;
      end else begin
        ex_valid  <= 1'b0;
        ex_wb     <= 1'b0;
        ex_memrd  <= 1'b0;
        ex_memwr  <= 1'b0;
        ex_result <= '0;
      end
    end
  end

endmodule

// File: tb/tb_exe_stage_fwd.sv
// Directed bench for exe_stage_fwd: forwarding, ALU ops, freeze, multiplier.
module tb_exe_stage_fwd;

  logic        CLK, RESET;
  logic        id_valid;
  logic [3:0]  id_op;
  logic [31:0] id_opa, id_opb, id_imm;
  logic [4:0]  id_rsa, id_rsb, id_wreg, id_shamt;
  logic        id_use_imm, id_wb, id_memrd, id_memwr;
  logic        mem_wb, wb_wb;
  logic [4:0]  mem_wreg, wb_wreg;
  logic [31:0] mem_data, wb_data;
  logic        freeze;
  logic        exe_busy, ex_valid, ex_wb, ex_memrd, ex_memwr;
  logic [31:0] ex_result, ex_storedata, hi, lo;
  logic [4:0]  ex_wreg;

  int total = 0;
  int bad   = 0;

  exe_stage_fwd #(.DW(32), .RW(5), .SW(5)) dut (
    .CLK(CLK), .RESET(RESET), .id_valid(id_valid), .id_op(id_op),
    .id_opa(id_opa), .id_opb(id_opb), .id_rsa(id_rsa), .id_rsb(id_rsb),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_shamt(id_shamt),
    .id_wreg(id_wreg), .id_wb(id_wb), .id_memrd(id_memrd), .id_memwr(id_memwr),
    .mem_wb(mem_wb), .wb_wb(wb_wb), .mem_wreg(mem_wreg), .wb_wreg(wb_wreg),
    .mem_data(mem_data), .wb_data(wb_data), .freeze(freeze),
    .exe_busy(exe_busy), .ex_valid(ex_valid), .ex_wb(ex_wb),
    .ex_memrd(ex_memrd), .ex_memwr(ex_memwr), .ex_result(ex_result),
    .ex_storedata(ex_storedata), .ex_wreg(ex_wreg), .hi(hi), .lo(lo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_op = 0; id_opa = 0; id_opb = 0; id_imm = 0;
    id_rsa = 0; id_rsb = 0; id_wreg = 0; id_shamt = 0;
    id_use_imm = 0; id_wb = 0; id_memrd = 0; id_memwr = 0;
    mem_wb = 0; wb_wb = 0; mem_wreg = 0; wb_wreg = 0;
    mem_data = 0; wb_data = 0; freeze = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    RESET = 1;
    tick(); tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ex_valid); end
    total++; if (ex_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", ex_result); end
    total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
    total++; if (exe_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", exe_busy); end
    RESET = 0;
  endtask

  task automatic test_add();
    clear_inputs();
    id_valid = 1; id_op = 0; id_opa = 5; id_opb = 7; id_rsa = 1; id_rsb = 2;
    id_wreg = 9; id_wb = 1;
    tick();
    total++; if (ex_result !== 32'd12) begin bad++; $display("FAIL add_result got=%h exp=%h", ex_result, 32'd12); end
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", ex_valid); end
    total++; if (ex_wreg !== 5'd9) begin bad++; $display("FAIL add_wreg got=%0d exp=9", ex_wreg); end
    total++; if (ex_wb !== 1'b1) begin bad++; $display("FAIL add_wb got=%b exp=1", ex_wb); end
    total++; if (ex_storedata !== 32'd7) begin bad++; $display("FAIL add_store got=%h exp=7", ex_storedata); end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    id_valid = 1; id_op = 3; id_opa = 32'h11; id_opb = 0; id_rsa = 3; id_rsb = 0;
    mem_wb = 1; mem_wreg = 3; mem_data = 32'hAA;
    wb_wb = 1; wb_wreg = 3; wb_data = 32'hBB;
    tick();
    total++; if (ex_result !== 32'hAA) begin bad++; $display("FAIL fwd_mem_prio got=%h exp=aa", ex_result); end
    mem_wb = 0;
    tick();
    total++; if (ex_result !== 32'hBB) begin bad++; $display("FAIL fwd_wb got=%h exp=bb", ex_result); end
    mem_wb = 1; id_rsa = 0; mem_wreg = 0; wb_wreg = 0;
    tick();
    total++; if (ex_result !== 32'h11) begin bad++; $display("FAIL fwd_r0 got=%h exp=11", ex_result); end
    // B forwarded to store data while the ALU uses the immediate
    id_op = 0; id_opa = 1; id_use_imm = 1; id_imm = 32'h10; id_rsb = 4; id_opb = 32'h55;
    mem_wb = 1; mem_wreg = 4; mem_data = 32'hAA; wb_wb = 0;
    tick();
    total++; if (ex_result !== 32'h11) begin bad++; $display("FAIL fwd_imm got=%h exp=11", ex_result); end
    total++; if (ex_storedata !== 32'hAA) begin bad++; $display("FAIL fwd_store got=%h exp=aa", ex_storedata); end
  endtask

  task automatic test_alu();
    logic [3:0]  ops [11] = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8, 4'd12, 4'd0};
    logic [31:0] as  [11] = '{32'h0, 32'hF0F0, 32'hF0F0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5, 32'hFFFFFFFF};
    logic [31:0] bs  [11] = '{32'h1, 32'h0FF0, 32'h0FF0, 32'h1, 32'hFFFFFFFF, 32'h1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h5, 32'h2};
    logic [4:0]  shs [11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd31, 5'd4, 5'd0, 5'd0};
    logic [31:0] exs [11] = '{32'hFFFFFFFF, 32'h00F0, 32'hFF00, 32'h1, 32'h0, 32'h80000000, 32'h1, 32'hFFFFFFFF, 32'h04000000, 32'h0, 32'h1};
    clear_inputs();
    for (int i = 0; i < 11; i++) begin
      id_valid = 1; id_op = ops[i]; id_opa = as[i]; id_opb = bs[i]; id_shamt = shs[i];
      tick();
      total++;
      if (ex_result !== exs[i] || ex_valid !== 1'b1) begin
        bad++; $display("FAIL alu_%0d op=%0d got=%h exp=%h", i, ops[i], ex_result, exs[i]);
      end
    end
  endtask

  task automatic test_freeze();
    clear_inputs();
    id_valid = 1; id_op = 0; id_opa = 5; id_opb = 7; id_wreg = 6; id_wb = 1;
    tick();
    id_op = 1; id_opa = 20; id_opb = 3; id_wreg = 8; freeze = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ex_result !== 32'd12 || ex_valid !== 1'b1 || ex_wreg !== 5'd6) begin
        bad++; $display("FAIL freeze_hold_%0d got=%h/%0d exp=%h/6", i, ex_result, ex_wreg, 32'd12);
      end
    end
    freeze = 0;
    tick();
    total++; if (ex_result !== 32'd17) begin bad++; $display("FAIL freeze_release got=%h exp=%h", ex_result, 32'd17); end
    total++; if (ex_wreg !== 5'd8) begin bad++; $display("FAIL freeze_wreg got=%0d exp=8", ex_wreg); end
  endtask

  task automatic test_mult();
    int n;
    clear_inputs();
    id_valid = 1; id_op = 9; id_opa = 32'hFFFFFFFF; id_opb = 2; id_wb = 1; id_wreg = 7;
    tick();
    id_valid = 0;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL mult_bubble got=%b exp=0", ex_valid); end
    n = 0;
    while (exe_busy === 1'b1 && n < 100) begin n++; tick(); end
    total++; if (n !== 32) begin bad++; $display("FAIL mult_busy_cycles got=%0d exp=32", n); end
    total++; if (hi !== 32'h1) begin bad++; $display("FAIL mult_hi got=%h exp=1", hi); end
    total++; if (lo !== 32'hFFFFFFFE) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffe", lo); end
    total++; if (ex_valid !== 1'b1 || ex_wb !== 1'b0) begin bad++; $display("FAIL mult_ex_ctl got=%b%b exp=10", ex_valid, ex_wb); end
    total++; if (ex_result !== 32'hFFFFFFFE) begin bad++; $display("FAIL mult_ex_result got=%h exp=fffffffe", ex_result); end
    id_valid = 1; id_op = 10; id_wb = 1;
    tick();
    total++; if (ex_result !== 32'h1) begin bad++; $display("FAIL mfhi got=%h exp=1", ex_result); end
    id_op = 11;
    tick();
    total++; if (ex_result !== 32'hFFFFFFFE) begin bad++; $display("FAIL mflo got=%h exp=fffffffe", ex_result); end
  endtask

  task automatic test_mult_freeze();
    clear_inputs();
    id_valid = 1; id_op = 9; id_opa = 3; id_opb = 5;
    tick();
    id_valid = 0;
    repeat (31) tick();
    total++; if (exe_busy !== 1'b1) begin bad++; $display("FAIL mfz_busy_pre got=%b exp=1", exe_busy); end
    freeze = 1;
    tick();
    total++; if (exe_busy !== 1'b1) begin bad++; $display("FAIL mfz_done_busy got=%b exp=1", exe_busy); end
    total++; if ({hi, lo} !== 64'd15) begin bad++; $display("FAIL mfz_hilo got=%h exp=f", {hi, lo}); end
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL mfz_ex_held got=%b exp=0", ex_valid); end
    tick();
    total++; if (exe_busy !== 1'b1) begin bad++; $display("FAIL mfz_done_stay got=%b exp=1", exe_busy); end
    freeze = 0;
    tick();
    total++; if (exe_busy !== 1'b0) begin bad++; $display("FAIL mfz_idle got=%b exp=0", exe_busy); end
    total++; if (ex_valid !== 1'b1 || ex_result !== 32'd15 || ex_wb !== 1'b0) begin
      bad++; $display("FAIL mfz_ex_load got=%b/%h/%b exp=1/f/0", ex_valid, ex_result, ex_wb);
    end
  endtask

  task automatic test_reset_mid_mult();
    clear_inputs();
    id_valid = 1; id_op = 9; id_opa = 7; id_opb = 9;
    tick();
    id_valid = 0;
    repeat (10) tick();
    RESET = 1;
    tick();
    total++; if (exe_busy !== 1'b0) begin bad++; $display("FAIL rst_mul_busy got=%b exp=0", exe_busy); end
    total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL rst_mul_hilo got=%h exp=0", {hi, lo}); end
    total++; if ({ex_valid, ex_wb, ex_memrd, ex_memwr} !== 4'b0 || ex_result !== 32'h0 || ex_wreg !== 5'h0 || ex_storedata !== 32'h0) begin
      bad++; $display("FAIL rst_mul_ex got=%b%b%b%b/%h exp=0000/0", ex_valid, ex_wb, ex_memrd, ex_memwr, ex_result);
    end
    RESET = 0;
    repeat (3) tick();
    total++; if (exe_busy !== 1'b0 || {hi, lo} !== 64'h0) begin bad++; $display("FAIL rst_mul_abort got=%b/%h exp=0/0", exe_busy, {hi, lo}); end
    id_valid = 1; id_op = 8; id_opb = 32'h80000000; id_shamt = 31;
    tick();
    total++; if (ex_result !== 32'hFFFFFFFF) begin bad++; $display("FAIL rst_sra got=%h exp=ffffffff", ex_result); end
  endtask

  initial begin
    RESET = 1;
    clear_inputs();
    test_reset();
    test_add();
    test_forwarding();
    test_alu();
    test_freeze();
    test_mult();
    test_mult_freeze();
    test_reset_mid_mult();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
